// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port and the
// data port. Data has default priority; a starvation counter forces a fetch
// grant after MAX_IF_WAIT consecutive lost conflicts, and accesses the memory
// never answers are aborted after MEM_TIMEOUT cycles with err_o.
// Optional feature macro: MEM_ARBITER_PERF_EN (adds grant/conflict counters).
module mem_arbiter #(
  parameter int unsigned MAX_IF_WAIT = 3,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        err_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_be_o,
  input  logic        m_ready_i,
  input  logic [31:0] m_rdata_i
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] perf_if_grants_o,
  output logic [31:0] perf_d_grants_o,
  output logic [31:0] perf_conflict_o
`endif
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned TO_W   = 10;
  localparam int unsigned DW     = 32;
  localparam int unsigned BEW    = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              own_d_q, own_d_d;   // 1: data port owns the access

  logic              m_req_d, m_we_d;
  logic [DW-1:0]     m_addr_d, m_wdata_d;
  logic [BEW-1:0]    m_be_d;
  logic              if_ack_d, d_ack_d, err_d;
  logic [DW-1:0]     if_rdata_d, d_rdata_d;

  logic              grant_if_c, grant_d_c, conflict_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Arbitration, access tracking and next values of every registered output
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    to_d       = to_q;
    own_d_d    = own_d_q;
    m_req_d    = m_req_o;
    m_we_d     = m_we_o;
    m_addr_d   = m_addr_o;
    m_wdata_d  = m_wdata_o;
    m_be_d     = m_be_o;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_o;
    d_rdata_d  = d_rdata_o;
    grant_if_c = 1'b0;
    grant_d_c  = 1'b0;
    conflict_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        conflict_c = if_req_i && d_req_i;
        if (if_req_i && (!d_req_i || (wait_q == WAIT_W'(MAX_IF_WAIT)))) begin
          grant_if_c = 1'b1;
        end else if (d_req_i) begin
          grant_d_c = 1'b1;
        end

        if (grant_if_c) begin
          own_d_d   = 1'b0;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr_i;
          m_wdata_d = '0;
          m_be_d    = 4'hF;
          wait_d    = '0;
        end else if (grant_d_c) begin
          own_d_d   = 1'b1;
          m_we_d    = d_we_i;
          m_addr_d  = d_addr_i;
          m_wdata_d = d_wdata_i;
          m_be_d    = d_be_i;
          if (conflict_c) wait_d = wait_q + WAIT_W'(1);
        end

        if (grant_if_c || grant_d_c) begin
          m_req_d = 1'b1;
          to_d    = '0;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (m_ready_i) begin
          m_req_d = 1'b0;
          if (!m_we_o) begin
            if (own_d_q) d_rdata_d  = m_rdata_i;
            else         if_rdata_d = m_rdata_i;
          end
          if_ack_d = !own_d_q;
          d_ack_d  = own_d_q;
          state_d  = S_RESP;
        end else if (to_q == TO_W'(MEM_TIMEOUT - 1)) begin
          m_req_d  = 1'b0;
          err_d    = 1'b1;
          if_ack_d = !own_d_q;
          d_ack_d  = own_d_q;
          state_d  = S_RESP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= '0;
      to_q       <= '0;
      own_d_q    <= 1'b0;
      m_req_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_addr_o   <= '0;
      m_wdata_o  <= '0;
      m_be_o     <= '0;
      if_ack_o   <= 1'b0;
      d_ack_o    <= 1'b0;
      err_o      <= 1'b0;
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else begin
      wait_q     <= wait_d;
      to_q       <= to_d;
      own_d_q    <= own_d_d;
      m_req_o    <= m_req_d;
      m_we_o     <= m_we_d;
      m_addr_o   <= m_addr_d;
      m_wdata_o  <= m_wdata_d;
      m_be_o     <= m_be_d;
      if_ack_o   <= if_ack_d;
      d_ack_o    <= d_ack_d;
      err_o      <= err_d;
      if_rdata_o <= if_rdata_d;
      d_rdata_o  <= d_rdata_d;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  // Free-running grant and conflict counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_grants_o <= '0;
      perf_d_grants_o  <= '0;
      perf_conflict_o  <= '0;
    end else begin
      if (grant_if_c) perf_if_grants_o <= perf_if_grants_o + 32'd1;
      if (grant_d_c)  perf_d_grants_o  <= perf_d_grants_o + 32'd1;
      if (conflict_c) perf_conflict_o  <= perf_conflict_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned MAX_W  = 3;
  localparam int unsigned MEM_TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i, d_req_i, d_we_i, m_ready_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, m_rdata_i;
  logic [3:0]  d_be_i;
  logic        if_ack_o, d_ack_o, err_o, m_req_o, m_we_o;
  logic [31:0] if_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
  logic [3:0]  m_be_o;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_if, perf_d, perf_conf;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_IF_WAIT(MAX_W), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .err_o(err_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_ready_i(m_ready_i), .m_rdata_i(m_rdata_i)
`ifdef MEM_ARBITER_PERF_EN
    , .perf_if_grants_o(perf_if), .perf_d_grants_o(perf_d), .perf_conflict_o(perf_conf)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_d_rd  = '0;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    int          lat;
    logic [31:0] rdv;
    logic        exp_d;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", nm, f, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input string f, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %b want %b", nm, f, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk1(nm, "m_req", m_req_o, 1'b0);
    chk1(nm, "if_ack", if_ack_o, 1'b0);
    chk1(nm, "d_ack", d_ack_o, 1'b0);
    chk1(nm, "err", err_o, 1'b0);
    chk1(nm, "m_we", m_we_o, 1'b0);
    chk(nm, "m_addr", m_addr_o, 32'h0);
    chk(nm, "m_wdata", m_wdata_o, 32'h0);
    chk(nm, "m_be", 32'(m_be_o), 32'h0);
    chk(nm, "if_rdata", if_rdata_o, 32'h0);
    chk(nm, "d_rdata", d_rdata_o, 32'h0);
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] db,
                              input int lat, input logic [31:0] rdv, input logic ed,
                              input logic [31:0] ea, input logic ew, input logic [3:0] eb,
                              input logic [31:0] ewd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.d_be = db; v.lat = lat; v.rdv = rdv; v.exp_d = ed;
    v.e_addr = ea; v.e_we = ew; v.e_be = eb; v.e_wdata = ewd;
    return v;
  endfunction

  // One complete access starting in an IDLE cycle with requests already driven
  task automatic xfer(input string nm, input logic ed, input logic [31:0] ea, input logic ew,
                      input logic [3:0] eb, input logic [31:0] ewd, input int lat,
                      input logic [31:0] rdv);
    tick();
    chk1(nm, "m_req_grant", m_req_o, 1'b1);
    chk(nm, "m_addr", m_addr_o, ea);
    chk1(nm, "m_we", m_we_o, ew);
    chk(nm, "m_be", 32'(m_be_o), 32'(eb));
    chk(nm, "m_wdata", m_wdata_o, ewd);
    for (int k = 0; k < lat; k++) begin
      m_ready_i = 1'b0;
      m_rdata_i = $urandom;
      tick();
      chk1(nm, "m_req_wait", m_req_o, 1'b1);
      chk(nm, "m_addr_stable", m_addr_o, ea);
    end
    m_ready_i = 1'b1;
    m_rdata_i = rdv;
    tick();
    m_ready_i = 1'b0;
    if (!ew) begin
      if (ed) exp_d_rd = rdv;
      else    exp_if_rd = rdv;
    end
    chk1(nm, "m_req_resp", m_req_o, 1'b0);
    chk1(nm, "if_ack", if_ack_o, !ed);
    chk1(nm, "d_ack", d_ack_o, ed);
    chk1(nm, "err", err_o, 1'b0);
    chk(nm, "if_rdata", if_rdata_o, exp_if_rd);
    chk(nm, "d_rdata", d_rdata_o, exp_d_rd);
    tick();
    chk1(nm, "if_ack_end", if_ack_o, 1'b0);
    chk1(nm, "d_ack_end", d_ack_o, 1'b0);
    chk1(nm, "m_req_idle", m_req_o, 1'b0);
  endtask

  task automatic drive(input vec_t v);
    if_req_i = v.if_req; if_addr_i = v.if_addr;
    d_req_i = v.d_req; d_we_i = v.d_we; d_addr_i = v.d_addr;
    d_wdata_i = v.d_wdata; d_be_i = v.d_be;
  endtask

  vec_t vecs[11];
  logic order_d[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] mem [16];

  // Random-phase model state
  int          age, lat, streak;
  logic        ack_prev, rdy_drv, own_d, ack_now, err_now;
  logic [31:0] t_addr, t_wdata, t_rdv;
  logic        t_we;
  logic [3:0]  t_be;
  logic [31:0] pc_if, pc_d, pc_conf;

  initial begin
    // Directed table
    vecs[0] = mk(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0010_0093,
                 1'b0, 32'h10, 1'b0, 4'hF, 32'h0);
    vecs[1] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 1, 32'h1234_5678,
                 1'b1, 32'h100, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    vecs[2] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h5555_AAAA, 4'hF, 2, 32'hCAFE_F00D,
                 1'b1, 32'h200, 1'b0, 4'hF, 32'h5555_AAAA);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ia, da;
      ia = 32'h40 + 32'(4 * i);
      da = 32'h300 + 32'(4 * i);
      vecs[3 + i] = mk(1'b1, ia, 1'b1, 1'b0, da, 32'h7000_0000 + 32'(i), 4'hF, i % 3,
                       32'hA000_0000 + 32'(i), order_d[i],
                       order_d[i] ? da : ia, 1'b0, 4'hF,
                       order_d[i] ? (32'h7000_0000 + 32'(i)) : 32'h0);
    end
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    rst_n = 1'b0;
    if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0;
    d_wdata_i = 0; d_be_i = 0; m_ready_i = 0; m_rdata_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
`ifdef MEM_ARBITER_PERF_EN
    chk("reset", "perf_if", perf_if, 32'd0);
    chk("reset", "perf_d", perf_d, 32'd0);
    chk("reset", "perf_conf", perf_conf, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i]);
      xfer($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].e_addr, vecs[i].e_we,
           vecs[i].e_be, vecs[i].e_wdata, vecs[i].lat, vecs[i].rdv);
    end
`ifdef MEM_ARBITER_PERF_EN
    chk("perf", "if_grants", perf_if, 32'd3);
    chk("perf", "d_grants", perf_d, 32'd8);
    chk("perf", "conflicts", perf_conf, 32'd8);
`endif

    // Two data wins build up fetch starvation, then reset mid-access clears it
    if_req_i = 1; if_addr_i = 32'h80; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400;
    d_wdata_i = 32'h0; d_be_i = 4'hF;
    xfer("pre_rst0", 1'b1, 32'h400, 1'b0, 4'hF, 32'h0, 0, 32'h1111_0000);
    xfer("pre_rst1", 1'b1, 32'h400, 1'b0, 4'hF, 32'h0, 1, 32'h1111_0001);
    tick();
    chk1("rst_mid", "m_req_before", m_req_o, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    exp_if_rd = '0;
    exp_d_rd  = '0;
    m_ready_i = 1'b1;
    m_rdata_i = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    m_ready_i = 1'b0;
    rst_n = 1'b1;
    chk1("rst_hold", "d_ack", d_ack_o, 1'b0);
    chk1("rst_hold", "if_ack", if_ack_o, 1'b0);
    xfer("post_rst0", 1'b1, 32'h400, 1'b0, 4'hF, 32'h0, 0, 32'h2222_0000);
    xfer("post_rst1", 1'b1, 32'h400, 1'b0, 4'hF, 32'h0, 0, 32'h2222_0001);
    xfer("post_rst2", 1'b1, 32'h400, 1'b0, 4'hF, 32'h0, 0, 32'h2222_0002);
    xfer("post_rst3", 1'b0, 32'h80, 1'b0, 4'hF, 32'h0, 0, 32'h3333_0003);

    // Memory never answers: abort after MEM_TO access cycles
    if_req_i = 0; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h44; d_be_i = 4'hC;
    m_ready_i = 0;
    tick();
    chk1("tmo", "m_req_c1", m_req_o, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk1("tmo", $sformatf("m_req_c%0d", k), m_req_o, 1'b1);
      chk1("tmo", "d_ack_early", d_ack_o, 1'b0);
    end
    tick();
    d_req_i = 0;
    chk1("tmo", "m_req_drop", m_req_o, 1'b0);
    chk1("tmo", "d_ack", d_ack_o, 1'b1);
    chk1("tmo", "err", err_o, 1'b1);
    chk1("tmo", "if_ack", if_ack_o, 1'b0);
    chk("tmo", "d_rdata_hold", d_rdata_o, exp_d_rd);
    tick();
    chk1("tmo", "err_end", err_o, 1'b0);
    chk1("tmo", "d_ack_end", d_ack_o, 1'b0);

    // Randomized run against a transaction-level model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_if_rd = '0; exp_d_rd = '0;
    age = -1; lat = 0; streak = 0; ack_prev = 0; rdy_drv = 0; own_d = 0;
    t_addr = 0; t_wdata = 0; t_rdv = 0; t_we = 0; t_be = 0;
    pc_if = 0; pc_d = 0; pc_conf = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      ack_now = 1'b0;
      err_now = 1'b0;
      if (ack_prev) begin
        age = -1;
      end else if (age >= 0) begin
        age++;
        if (rdy_drv) ack_now = 1'b1;
        else if (age == int'(MEM_TO)) begin ack_now = 1'b1; err_now = 1'b1; end
      end else if (if_req_i || d_req_i) begin
        own_d = d_req_i && !(if_req_i && streak == int'(MAX_W));
        if (own_d && if_req_i) streak++;
        else if (!own_d) streak = 0;
        if (if_req_i && d_req_i) pc_conf++;
        if (own_d) begin
          t_addr = d_addr_i; t_we = d_we_i; t_be = d_be_i; t_wdata = d_wdata_i; pc_d++;
        end else begin
          t_addr = if_addr_i; t_we = 1'b0; t_be = 4'hF; t_wdata = 32'h0; pc_if++;
        end
        age = 0;
        lat = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 3));
      end
      if (ack_now && !err_now && !t_we) begin
        if (own_d) exp_d_rd = t_rdv;
        else       exp_if_rd = t_rdv;
      end
      chk1("rnd", "m_req", m_req_o, (age >= 0) && !ack_now);
      chk1("rnd", "if_ack", if_ack_o, ack_now && !own_d);
      chk1("rnd", "d_ack", d_ack_o, ack_now && own_d);
      chk1("rnd", "err", err_o, err_now);
      chk("rnd", "if_rdata", if_rdata_o, exp_if_rd);
      chk("rnd", "d_rdata", d_rdata_o, exp_d_rd);
      if (age >= 0) begin
        chk("rnd", "m_addr", m_addr_o, t_addr);
        chk1("rnd", "m_we", m_we_o, t_we);
        chk("rnd", "m_be", 32'(m_be_o), 32'(t_be));
        chk("rnd", "m_wdata", m_wdata_o, t_wdata);
      end
`ifdef MEM_ARBITER_PERF_EN
      chk("rnd", "perf_if", perf_if, pc_if);
      chk("rnd", "perf_d", perf_d, pc_d);
      chk("rnd", "perf_conf", perf_conf, pc_conf);
`endif
      ack_prev = ack_now;

      // Memory: answer after the chosen latency, stores update the array
      if ((age >= 0) && !ack_now && (age == lat)) begin
        t_rdv = mem[t_addr[5:2]];
        m_ready_i = 1'b1;
        m_rdata_i = t_rdv;
        if (t_we) begin
          for (int b = 0; b < 4; b++) begin
            if (t_be[b]) mem[t_addr[5:2]][8*b +: 8] = t_wdata[8*b +: 8];
          end
        end
      end else begin
        m_ready_i = 1'b0;
        m_rdata_i = $urandom;
      end
      rdy_drv = m_ready_i;

      // Requesters hold until ack, then may drop or issue a new request
      if (ack_now && !own_d) begin
        if_req_i = ($urandom_range(0, 3) != 0);
        if_addr_i = $urandom;
      end else if (!if_req_i && ($urandom_range(0, 2) == 0)) begin
        if_req_i = 1'b1;
        if_addr_i = $urandom;
      end
      if ((ack_now && own_d) || (!d_req_i && ($urandom_range(0, 2) == 0))) begin
        d_req_i = (ack_now && own_d) ? ($urandom_range(0, 3) != 0) : 1'b1;
        d_we_i = 1'($urandom_range(0, 1));
        d_addr_i = $urandom;
        d_wdata_i = $urandom;
        d_be_i = 4'($urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
